// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory responder: address map,
// framebuffer write-entry layout and the address region classification.
package hack_mem_pkg;

  localparam int          RAM_WORDS    = 16384;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [15:0] SCREEN_BASE  = 16'h4000;
  localparam logic [15:0] KBD_ADDR     = 16'h6000;
  localparam int          FIFO_DEPTH   = 8;

  localparam int FB_ADDR_W  = 13;
  localparam int FB_DATA_W  = 16;
  localparam int FB_ENTRY_W = FB_ADDR_W + FB_DATA_W;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_SCREEN,
    RGN_KBD,
    RGN_UNMAPPED
  } region_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/screen_write_fifo.sv
// Synchronous FIFO for posted screen writes. A push into a full FIFO is still
// accepted when the head is popped in the same cycle; otherwise it is dropped.
module screen_write_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_fire;
  logic             push_fire;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);
  assign dropped   = push && !push_fire;
  assign head_data = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, shadowed screen with posted framebuffer
// writes, and a memory-mapped keyboard register. Reads are combinational.
module hack_data_memory #(
  parameter int          RAM_WORDS    = hack_mem_pkg::RAM_WORDS,
  parameter logic [15:0] SCREEN_BASE  = hack_mem_pkg::SCREEN_BASE,
  parameter int          SCREEN_WORDS = hack_mem_pkg::SCREEN_WORDS,
  parameter logic [15:0] KBD_ADDR     = hack_mem_pkg::KBD_ADDR,
  parameter int          FIFO_DEPTH   = hack_mem_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  input  logic        kbd_strobe,
  input  logic [15:0] kbd_code,
  input  logic        kbd_release,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        bus_error
);

  import hack_mem_pkg::*;

  localparam int          RAM_AW  = $clog2(RAM_WORDS);
  localparam int          SCR_AW  = $clog2(SCREEN_WORDS);
  localparam logic [16:0] RAM_END = 17'(RAM_WORDS);
  localparam logic [16:0] SCR_LO  = {1'b0, SCREEN_BASE};
  localparam logic [16:0] SCR_HI  = 17'(int'(SCREEN_BASE) + SCREEN_WORDS);

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];

  region_t     region;
  logic [16:0] addr_ext;
  logic [12:0] scr_off;
  logic [15:0] kbd_reg;
  logic        overflow_reg;
  logic [7:0]  drop_count_reg;
  logic        bus_error_reg;
  logic        ram_we;
  logic        scr_we;
  fb_entry_t   push_entry;
  fb_entry_t   head_entry;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_dropped;

  // Widened by one bit so SCREEN_BASE+SCREEN_WORDS cannot wrap.
  assign addr_ext = {1'b0, addressM};
  assign scr_off  = 13'(addressM - SCREEN_BASE);

  always_comb begin
    region = RGN_UNMAPPED;
    if (addr_ext < RAM_END)                          region = RGN_RAM;
    else if (addr_ext >= SCR_LO && addr_ext < SCR_HI) region = RGN_SCREEN;
    else if (addressM == KBD_ADDR)                   region = RGN_KBD;
  end

  always_comb begin
    inM = 16'h0000;
    case (region)
      RGN_RAM:    inM = ram[addressM[RAM_AW-1:0]];
      RGN_SCREEN: inM = screen[scr_off[SCR_AW-1:0]];
      RGN_KBD:    inM = kbd_reg;
      default:    inM = 16'h0000;
    endcase
  end

  assign ram_we = writeM && (region == RGN_RAM);
  assign scr_we = writeM && (region == RGN_SCREEN);

  always_ff @(posedge clk) begin
    if (ram_we) ram[addressM[RAM_AW-1:0]] <= outM;
    if (scr_we) screen[scr_off[SCR_AW-1:0]] <= outM;
  end

  assign push_entry.addr = scr_off;
  assign push_entry.data = outM;

  screen_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FB_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (scr_we),
    .push_data (push_entry),
    .pop       (fb_ready),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign fb_valid = !fifo_empty;
  assign fb_addr  = head_entry.addr;
  assign fb_data  = head_entry.data;

  // A strobe takes priority over a simultaneous release.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_reg        <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      bus_error_reg  <= 1'b0;
    end else begin
      if (kbd_strobe)       kbd_reg <= kbd_code;
      else if (kbd_release) kbd_reg <= '0;
      if (fifo_dropped) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
      end
      if (region == RGN_UNMAPPED) bus_error_reg <= 1'b1;
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign bus_error  = bus_error_reg;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Responder side of the CPU data-memory interface (addressM/writeM/outM in, inM out).
- Implements the Hack data address map: general RAM, a screen region with shadow storage plus posted writes to an external framebuffer, and a memory-mapped keyboard register.
- Sits between the CPU and the display/keyboard front-ends, and never stalls the CPU.

Parameters:
- RAM_WORDS, 16384, general RAM depth; occupies addresses 0x0000 to RAM_WORDS-1.
- SCREEN_BASE, 16'h4000, first screen address.
- SCREEN_WORDS, 8192, screen region depth.
- KBD_ADDR, 16'h6000, keyboard register address.
- FIFO_DEPTH, 8, posted-write FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addressM  in  16  CPU data address.
- writeM  in  1  CPU write enable, qualified per cycle.
- outM  in  16  CPU write data.
- inM  out  16  read data for addressM, combinational (same cycle).
- fb_valid  out  1  framebuffer write pending at FIFO head.
- fb_ready  in  1  framebuffer accepts the head entry this cycle.
- fb_addr  out  13  screen word offset (addressM - SCREEN_BASE).
- fb_data  out  16  screen word data.
- kbd_strobe  in  1  new key pressed; kbd_code valid this cycle.
- kbd_code  in  16  key code.
- kbd_release  in  1  key released.
- overflow  out  1  sticky: a screen write was dropped because the FIFO was full.
- drop_count  out  8  saturating count of dropped screen writes.
- bus_error  out  1  sticky: access to an unmapped address.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO pointers and count go to 0, so fb_valid=0.
  - Keyboard register, overflow, drop_count and bus_error go to 0.
  - RAM and screen shadow contents are not cleared.
- Address decode:
  - RAM: addressM < RAM_WORDS.
  - Screen: SCREEN_BASE <= addressM < SCREEN_BASE+SCREEN_WORDS.
  - Keyboard: addressM == KBD_ADDR.
  - Everything else is unmapped.
- Reads (combinational):
  - RAM and screen return the stored word.
  - Keyboard returns the keyboard register.
  - Unmapped returns 16'h0000.
- Write timing: a write with writeM=1 takes effect at the rising edge; a read of the same address in the next cycle returns the new data.
- RAM and screen writes:
  - RAM write updates RAM.
  - Screen write updates the shadow and pushes {offset, data} into the FIFO.
- Keyboard and unmapped writes:
  - A keyboard write is ignored.
  - An unmapped write is ignored.
- bus_error: set on any cycle where addressM is unmapped, whether the access is a read (writeM=0) or a write (writeM=1). It is cleared only by reset.
- FIFO:
  - Registered entries; fb_addr/fb_data show the head combinationally and fb_valid = (count != 0).
  - A push is visible at the head no earlier than the cycle after the write edge.
  - A pop occurs when fb_valid && fb_ready.
  - A push is accepted when count < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle; count is then unchanged.
  - A push when full with no pop is dropped: the shadow is still updated, overflow is set, and drop_count increments, saturating at 255.
  - Pointers wrap modulo FIFO_DEPTH.
  - fb_addr/fb_data stay stable while fb_valid && !fb_ready.
- Keyboard register:
  - kbd_strobe loads kbd_code.
  - kbd_release clears the register to 0.
  - If both are asserted in the same cycle, strobe wins.
  - The new value is readable the cycle after the edge; a same-cycle read returns the old value.
- Reset mid-operation: pending FIFO entries are discarded, and fb_valid deasserts in the cycle after the reset edge.

Decomposition:
- Shared package hack_mem_pkg holds:
  - address map constants: SCREEN_BASE, KBD_ADDR, RAM_WORDS, SCREEN_WORDS;
  - fb entry width: 13+16 bits;
  - a region enum: RAM, SCREEN, KBD, UNMAPPED.
- One sub-module, screen_write_fifo:
  - synchronous FIFO with push, pop, full and empty signals;
  - the same-cycle push-when-full-with-pop rule;
  - parameterised by depth and width.

Test Plan:
- RAM and screen round trip: write 16'h1234 to 0x0005, then read 0x0005 in the next cycle -> inM=16'h1234.
- Screen posting: write 16'hFFFF to 0x4010 with fb_ready=0 -> shadow reads 16'hFFFF next cycle; fb_valid=1, fb_addr=13'h0010, fb_data=16'hFFFF, held stable until fb_ready=1 pops it.
- Overflow: with fb_ready=0, perform 9 screen writes -> 8 queued; 9th dropped with overflow=1 and drop_count=1.
- Overflow boundary: repeat the full-FIFO case with fb_ready=1 on the 9th write -> push accepted, count stays 8, overflow stays 0.
- Keyboard: kbd_strobe with code 16'h0041 -> read of 0x6000 gives 16'h0041 next cycle.
- Keyboard priority: assert strobe with code 16'h0042 and release in the same cycle -> register reads 16'h0042; release alone -> register reads 16'h0000.
- Unmapped and reset: read 0x6001 -> inM=0 and bus_error=1; write 0x7000 -> ignored; assert reset with 3 FIFO entries pending -> fb_valid=0, bus_error=0, overflow=0, and RAM still holds 16'h1234 at 0x0005.
